iob_axi_burst_writer: RTL and testbench
=======================================

// Module: iob_axi_burst_writer
// PURPOSE
//  AXI4 write-burst engine for the iob-to-AXI bridge write path. It sits between the bridge's burst sequencer and the AXI write channels.
//  On run_i it issues one INCR burst of length_i+1 beats. Beat data is pulled from a native read port (the bridge input FIFO).
//  It then collects the write response and reports ready/error back to the sequencer.
// PARAMETERS
//  ADDR_W  32  byte address width (native and AXI)
//  DATA_W  32  data width; power of 2, >=8
//  LEN_W   8   burst length field width (AXI4 awlen)
// PORTS
//  clk_i            in   1          clock
//  rst_i            in   1          reset, asynchronous, active-high
//  run_i            in   1          start burst (sampled only in IDLE)
//  addr_i           in   ADDR_W     burst start byte address, DATA_W/8 aligned, burst must not cross 4KB
//  length_i         in   LEN_W      beats minus 1
//  ready_o          out  1          engine idle, may accept run_i
//  error_o          out  1          last burst got bresp!=OKAY; sticky until next accepted run_i
//  m_axi_awaddr_o   out  ADDR_W     burst address
//  m_axi_awlen_o    out  LEN_W      = latched length_i
//  m_axi_awsize_o   out  3          = clog2(DATA_W/8)
//  m_axi_awburst_o  out  2          = 2'b01 (INCR)
//  m_axi_awvalid_o  out  1          AW valid
//  m_axi_awready_i  in   1          AW ready
//  m_axi_wdata_o    out  DATA_W     write data
//  m_axi_wstrb_o    out  DATA_W/8   write strobes
//  m_axi_wlast_o    out  1          final beat
//  m_axi_wvalid_o   out  1          W valid
//  m_axi_wready_i   in   1          W ready
//  m_axi_bresp_i    in   2          write response
//  m_axi_bvalid_i   in   1          B valid
//  m_axi_bready_o   out  1          B ready
//  m_valid_o        out  1          native read request (one word per cycle high)
//  m_addr_o         out  ADDR_W     byte address of requested word
//  m_rdata_i        in   DATA_W     returned word
//  m_rstrb_i        in   DATA_W/8   returned strobes
//  m_ready_i        in   1          returned word valid
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, ready_o=1, error_o=0.
//   - all valid outputs=0, bready=0.
//   - internal beat counters=0, buffer empty.
//  FSM IDLE->ADDR->DATA->RESP->IDLE:
//   - IDLE: ready_o=1. run_i latches addr_i/length_i, clears error_o, goes to ADDR. ready_o drops the next cycle.
//   - ADDR: awvalid=1 with stable awaddr/awlen until awready; then DATA.
//   - DATA: streams length_i+1 beats. wlast=1 exactly on beat length_i. After that beat's wvalid&wready handshake, goes to RESP.
//   - RESP: bready=1. On bvalid, error_o<=(bresp!=2'b00), then IDLE.
//   - run_i outside IDLE is ignored.
//  Native read protocol:
//   - Each cycle m_valid_o=1 is one word request.
//   - Data for that request is valid in the next cycle iff m_ready_i=1.
//   - If m_ready_i=0 in that cycle, the request is dropped and the same m_addr_o is reissued later.
//  Buffering:
//   - 2-entry W skid buffer.
//   - m_valid_o = DATA & (words_got < length+1) & (buf_cnt + inflight < 2).
//   - No word is ever lost when wready stalls.
//   - Requests may start in ADDR (prefetch) under the same credit rule.
//  Address arithmetic:
//   - m_addr_o = base + words_got*(DATA_W/8), in ADDR_W-bit modulo.
//   - Counters are LEN_W+1 bits so length_i=2^LEN_W-1 (256 beats) counts correctly.
//  W channel:
//   - wvalid = buffer non-empty; wdata/wstrb come from the buffer head.
//   - wvalid is not retracted once asserted until wready.
//  Boundary cases:
//   - Simultaneous buffer push and pop keeps the count.
//   - length_i=0 gives a single beat with wlast=1.
//   - bvalid arriving before RESP is not possible (AXI); bvalid is ignored outside RESP.
//  Reset mid-burst: immediate return to IDLE, outputs to reset values, buffer and counters cleared.
//  Latency (all readies high): run_i -> awvalid 1 cycle; first wvalid 2 cycles after first m_valid_o.
// TESTING
//  1. run_i, addr=0x100, len=0, m_ready always 1, all AXI ready=1 -> awaddr=0x100, awlen=0, 1 W beat wlast=1, bresp=0 -> error_o=0, ready_o=1.
//  2. len=15, addr=0x1000, wready toggling 1/0 -> 16 beats in order, m_addr 0x1000..0x103C, wlast only on beat 16, no loss/duplication.
//  3. len=3, m_ready_i=0 on 2nd request -> address 0x..4 reissued, AXI data sequence intact.
//  4. bresp=2'b10 -> error_o=1 after B handshake; next run_i clears it the next cycle.
//  5. run_i pulsed during DATA -> ignored, awvalid not re-raised, burst completes normally.
//  6. rst_i asserted mid-DATA at beat 5 of 8 -> all valids 0 and ready_o=1 during reset; a new burst after reset completes correctly.

Source files
------------

// File: rtl/iob_axi_burst_writer_if.sv
// Bus bundle for iob_axi_burst_writer: the AXI4 write channels (AW, W, B)
// plus the native read port that feeds beat data from the bridge input FIFO.
//   master : the burst engine (drives AW/W/bready and native requests)
//   slave  : the AXI slave and the native FIFO side
interface iob_axi_burst_writer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    // AXI write address channel
    logic [ADDR_W-1:0]   m_axi_awaddr_o;
    logic [LEN_W-1:0]    m_axi_awlen_o;
    logic [2:0]          m_axi_awsize_o;
    logic [1:0]          m_axi_awburst_o;
    logic                m_axi_awvalid_o;
    logic                m_axi_awready_i;
    // AXI write data channel
    logic [DATA_W-1:0]   m_axi_wdata_o;
    logic [DATA_W/8-1:0] m_axi_wstrb_o;
    logic                m_axi_wlast_o;
    logic                m_axi_wvalid_o;
    logic                m_axi_wready_i;
    // AXI write response channel
    logic [1:0]          m_axi_bresp_i;
    logic                m_axi_bvalid_i;
    logic                m_axi_bready_o;
    // Native read port
    logic                m_valid_o;
    logic [ADDR_W-1:0]   m_addr_o;
    logic [DATA_W-1:0]   m_rdata_i;
    logic [DATA_W/8-1:0] m_rstrb_i;
    logic                m_ready_i;

    modport master (
        output m_axi_awaddr_o, m_axi_awlen_o, m_axi_awsize_o, m_axi_awburst_o,
               m_axi_awvalid_o,
        input  m_axi_awready_i,
        output m_axi_wdata_o, m_axi_wstrb_o, m_axi_wlast_o, m_axi_wvalid_o,
        input  m_axi_wready_i,
        input  m_axi_bresp_i, m_axi_bvalid_i,
        output m_axi_bready_o,
        output m_valid_o, m_addr_o,
        input  m_rdata_i, m_rstrb_i, m_ready_i
    );

    modport slave (
        input  m_axi_awaddr_o, m_axi_awlen_o, m_axi_awsize_o, m_axi_awburst_o,
               m_axi_awvalid_o,
        output m_axi_awready_i,
        input  m_axi_wdata_o, m_axi_wstrb_o, m_axi_wlast_o, m_axi_wvalid_o,
        output m_axi_wready_i,
        output m_axi_bresp_i, m_axi_bvalid_i,
        input  m_axi_bready_o,
        input  m_valid_o, m_addr_o,
        output m_rdata_i, m_rstrb_i, m_ready_i
    );
endinterface

// File: rtl/iob_axi_burst_writer.sv
// AXI4 write-burst engine for the iob-to-AXI bridge write path.
// On run_i (accepted only while idle) it issues one INCR burst of
// length_i+1 beats, pulls beat data from the native read port into a
// 2-entry skid buffer, streams it on W, then collects the B response.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   run_i          start a burst (sampled only when idle)
//   addr_i         burst start byte address (DATA_W/8 aligned, no 4KB cross)
//   length_i       beats minus one
//   ready_o        engine idle
//   error_o        last burst returned bresp != OKAY (sticky until next run)
//   bus            AXI AW/W/B channels and native read port (master modport)
module iob_axi_burst_writer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  length_i,
    output logic              ready_o,
    output logic              error_o,
    iob_axi_burst_writer_if.master bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int SIZE   = $clog2(STRB_W);
    localparam int CNT_W  = LEN_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Burst parameters (data path, not reset)
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;

    // Control state
    logic [CNT_W-1:0]  r_req_cnt;   // words requested and not dropped
    logic [CNT_W-1:0]  r_beat_cnt;  // W beats handshaked
    logic              r_inflight;  // a native request was issued last cycle
    logic              r_squash;    // that request must be discarded
    logic [1:0]        r_buf_cnt;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic              r_error;

    // Skid buffer storage
    logic [DATA_W-1:0] r_buf_data [2];
    logic [STRB_W-1:0] r_buf_strb [2];

    logic [CNT_W-1:0]  w_total;
    logic              w_credit_ok;
    logic              w_req;
    logic              w_push;
    logic              w_drop;
    logic              w_wvalid;
    logic              w_wlast;
    logic              w_pop;
    logic              w_awvalid;
    logic              w_bready;
    logic              w_ready;
    logic [ADDR_W-1:0] w_req_off;

    assign w_total     = {1'b0, r_len} + CNT_W'(1);
    assign w_credit_ok = ({1'b0, r_buf_cnt} + {2'b00, r_inflight}) < 3'd2;
    assign w_req       = ((r_state == ST_ADDR) || (r_state == ST_DATA)) &&
                         (r_req_cnt < w_total) && w_credit_ok;
    assign w_push      = r_inflight && !r_squash &&  bus.m_ready_i;
    assign w_drop      = r_inflight && !r_squash && !bus.m_ready_i;

    // W is only presented in DATA so the final beat is always seen by the FSM,
    // even when prefetched words are already buffered during ADDR.
    assign w_wvalid    = (r_state == ST_DATA) && (r_buf_cnt != 2'd0);
    assign w_wlast     = w_wvalid && (r_beat_cnt == {1'b0, r_len});
    assign w_pop       = w_wvalid && bus.m_axi_wready_i;
    assign w_req_off   = {{(ADDR_W-CNT_W){1'b0}}, r_req_cnt} << SIZE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_awvalid    = 1'b0;
        w_bready     = 1'b0;
        w_ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (run_i) w_next_state = ST_ADDR;
            end
            ST_ADDR: begin
                w_awvalid = 1'b1;
                if (bus.m_axi_awready_i) w_next_state = ST_DATA;
            end
            ST_DATA: begin
                if (w_pop && w_wlast) w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_bready = 1'b1;
                if (bus.m_axi_bvalid_i) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if ((r_state == ST_IDLE) && run_i) begin
            r_base <= addr_i;
            r_len  <= length_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_buf_data[r_wr_ptr] <= bus.m_rdata_i;
            r_buf_strb[r_wr_ptr] <= bus.m_rstrb_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req_cnt  <= '0;
            r_beat_cnt <= '0;
            r_inflight <= 1'b0;
            r_squash   <= 1'b0;
            r_buf_cnt  <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_error    <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (run_i) begin
                r_req_cnt  <= '0;
                r_beat_cnt <= '0;
                r_inflight <= 1'b0;
                r_squash   <= 1'b0;
                r_buf_cnt  <= 2'd0;
                r_wr_ptr   <= 1'b0;
                r_rd_ptr   <= 1'b0;
                r_error    <= 1'b0;
            end
        end else begin
            r_inflight <= w_req;
            // A dropped word rewinds the request counter. A request issued in
            // the same cycle targets the address after the dropped one, so it
            // is squashed and will be reissued in order.
            if (w_drop) begin
                r_req_cnt <= r_req_cnt - CNT_W'(1);
                r_squash  <= w_req;
            end else begin
                if (w_req) r_req_cnt <= r_req_cnt + CNT_W'(1);
                r_squash <= 1'b0;
            end
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop) begin
                r_rd_ptr   <= ~r_rd_ptr;
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_buf_cnt <= r_buf_cnt + 2'd1;
                2'b01:   r_buf_cnt <= r_buf_cnt - 2'd1;
                default: r_buf_cnt <= r_buf_cnt;
            endcase
            if ((r_state == ST_RESP) && bus.m_axi_bvalid_i)
                r_error <= (bus.m_axi_bresp_i != 2'b00);
        end
    end

    assign ready_o             = w_ready;
    assign error_o             = r_error;
    assign bus.m_axi_awaddr_o  = r_base;
    assign bus.m_axi_awlen_o   = r_len;
    assign bus.m_axi_awsize_o  = 3'(SIZE);
    assign bus.m_axi_awburst_o = 2'b01;
    assign bus.m_axi_awvalid_o = w_awvalid;
    assign bus.m_axi_wdata_o   = r_buf_data[r_rd_ptr];
    assign bus.m_axi_wstrb_o   = r_buf_strb[r_rd_ptr];
    assign bus.m_axi_wlast_o   = w_wlast;
    assign bus.m_axi_wvalid_o  = w_wvalid;
    assign bus.m_axi_bready_o  = w_bready;
    assign bus.m_valid_o       = w_req;
    assign bus.m_addr_o        = r_base + w_req_off;
endmodule

// File: tb/tb_iob_axi_burst_writer.sv
module tb_iob_axi_burst_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [31:0] addr = '0;
    logic [7:0]  len = '0;
    logic        ready;
    logic        error;

    int checks = 0;
    int errors = 0;

    // Environment configuration
    bit       wready_toggle = 1'b0;
    int       drop_req = -1;
    logic [1:0] bresp_cfg = 2'b00;

    // Monitor records
    int          req_idx = 0;
    int          aw_cnt = 0;
    logic [31:0] aw_addr_seen = '0;
    logic [7:0]  aw_len_seen = '0;
    logic [31:0] req_log[$];
    logic [31:0] wdata_q[$];
    logic [3:0]  wstrb_q[$];
    bit          wlast_q[$];

    iob_axi_burst_writer_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) bus ();

    iob_axi_burst_writer #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .run_i    (run),
        .addr_i   (addr),
        .length_i (len),
        .ready_o  (ready),
        .error_o  (error),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [3:0] mstrb(input logic [31:0] a);
        return a[5:2] ^ 4'b1010;
    endfunction

    // Native FIFO model, AXI slave model and W-channel monitor
    initial begin
        logic        v;
        logic [31:0] a;
        logic        w_last_hs;
        logic        b_hs;
        logic        prev_stall;
        logic [31:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        bus.m_axi_awready_i = 1'b1;
        bus.m_axi_wready_i  = 1'b1;
        bus.m_axi_bvalid_i  = 1'b0;
        bus.m_axi_bresp_i   = 2'b00;
        bus.m_ready_i       = 1'b0;
        bus.m_rdata_i       = '0;
        bus.m_rstrb_i       = '0;
        forever begin
            @(negedge clk);
            v = bus.m_valid_o;
            a = bus.m_addr_o;
            w_last_hs = 1'b0;
            b_hs = 1'b0;
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (v) req_log.push_back(a);
                if (bus.m_axi_awvalid_o && bus.m_axi_awready_i) begin
                    aw_cnt++;
                    aw_addr_seen = bus.m_axi_awaddr_o;
                    aw_len_seen  = bus.m_axi_awlen_o;
                end
                if (prev_stall) begin
                    checks++;
                    if (bus.m_axi_wvalid_o !== 1'b1 || bus.m_axi_wdata_o !== prev_data) begin
                        errors++;
                        $display("FAIL w_hold: wvalid=%0b wdata=%h required wvalid=1 wdata=%h",
                                 bus.m_axi_wvalid_o, bus.m_axi_wdata_o, prev_data);
                    end
                end
                prev_stall = bus.m_axi_wvalid_o && !bus.m_axi_wready_i;
                prev_data  = bus.m_axi_wdata_o;
                if (bus.m_axi_wvalid_o && bus.m_axi_wready_i) begin
                    wdata_q.push_back(bus.m_axi_wdata_o);
                    wstrb_q.push_back(bus.m_axi_wstrb_o);
                    wlast_q.push_back(bus.m_axi_wlast_o);
                    w_last_hs = bus.m_axi_wlast_o;
                end
                b_hs = bus.m_axi_bvalid_i && bus.m_axi_bready_o;
            end
            @(posedge clk);
            #1;
            if (rst) begin
                bus.m_ready_i      = 1'b0;
                bus.m_axi_bvalid_i = 1'b0;
                bus.m_axi_wready_i = 1'b1;
            end else begin
                if (v) begin
                    bus.m_ready_i = (req_idx != drop_req);
                    bus.m_rdata_i = mdata(a);
                    bus.m_rstrb_i = mstrb(a);
                    req_idx++;
                end else begin
                    bus.m_ready_i = 1'b0;
                end
                bus.m_axi_wready_i = wready_toggle ? ~bus.m_axi_wready_i : 1'b1;
                if (b_hs) bus.m_axi_bvalid_i = 1'b0;
                if (w_last_hs) begin
                    bus.m_axi_bvalid_i = 1'b1;
                    bus.m_axi_bresp_i  = bresp_cfg;
                end
            end
        end
    end

    task automatic start_burst(input logic [31:0] a, input logic [7:0] l);
        req_log.delete();
        wdata_q.delete();
        wstrb_q.delete();
        wlast_q.delete();
        aw_cnt  = 0;
        req_idx = 0;
        @(posedge clk);
        #1;
        run  = 1'b1;
        addr = a;
        len  = l;
        @(posedge clk);
        #1;
        run = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (ready === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: ready=%0b required ready=1 within 1000 cycles", name, ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", ready); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %0b want 0", error); end
        checks++; if (bus.m_axi_awvalid_o !== 1'b0) begin errors++; $display("FAIL rst_awvalid: got %0b want 0", bus.m_axi_awvalid_o); end
        checks++; if (bus.m_axi_wvalid_o !== 1'b0) begin errors++; $display("FAIL rst_wvalid: got %0b want 0", bus.m_axi_wvalid_o); end
        checks++; if (bus.m_axi_bready_o !== 1'b0) begin errors++; $display("FAIL rst_bready: got %0b want 0", bus.m_axi_bready_o); end
        checks++; if (bus.m_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mvalid: got %0b want 0", bus.m_valid_o); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        wready_toggle = 1'b0;
        drop_req = -1;
        bresp_cfg = 2'b00;
        start_burst(32'h0000_0100, 8'd0);
        checks++; if (bus.m_axi_awvalid_o !== 1'b1) begin errors++; $display("FAIL single_aw_latency: awvalid=%0b want 1", bus.m_axi_awvalid_o); end
        checks++; if (bus.m_valid_o !== 1'b1 || bus.m_addr_o !== 32'h100) begin errors++; $display("FAIL single_prefetch: m_valid=%0b m_addr=%h want 1/00000100", bus.m_valid_o, bus.m_addr_o); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_ready_drop: got %0b want 0", ready); end
        @(posedge clk); #1;
        checks++; if (bus.m_axi_wvalid_o !== 1'b0) begin errors++; $display("FAIL single_w_early: wvalid=%0b want 0", bus.m_axi_wvalid_o); end
        @(posedge clk); #1;
        checks++; if (bus.m_axi_wvalid_o !== 1'b1) begin errors++; $display("FAIL single_w_latency: wvalid=%0b want 1", bus.m_axi_wvalid_o); end
        wait_idle("single");
        checks++; if (aw_cnt !== 1 || aw_addr_seen !== 32'h100 || aw_len_seen !== 8'd0) begin errors++; $display("FAIL single_aw: cnt=%0d addr=%h len=%0d want 1/00000100/0", aw_cnt, aw_addr_seen, aw_len_seen); end
        checks++; if (bus.m_axi_awsize_o !== 3'd2 || bus.m_axi_awburst_o !== 2'b01) begin errors++; $display("FAIL single_awsize_burst: size=%0d burst=%0d want 2/1", bus.m_axi_awsize_o, bus.m_axi_awburst_o); end
        checks++;
        if (wdata_q.size() != 1) begin
            errors++; $display("FAIL single_beats: got %0d want 1", wdata_q.size());
        end else if (wdata_q[0] !== mdata(32'h100) || wstrb_q[0] !== mstrb(32'h100) || wlast_q[0] !== 1'b1) begin
            errors++; $display("FAIL single_beat0: data=%h strb=%h last=%0b want %h/%h/1", wdata_q[0], wstrb_q[0], wlast_q[0], mdata(32'h100), mstrb(32'h100));
        end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL single_error: got %0b want 0", error); end
    endtask

    task automatic test_wready_toggle();
        logic [31:0] base;
        base = 32'h0000_1000;
        wready_toggle = 1'b1;
        drop_req = -1;
        start_burst(base, 8'd15);
        wait_idle("toggle");
        wready_toggle = 1'b0;
        checks++; if (req_log.size() != 16) begin errors++; $display("FAIL toggle_req_count: got %0d want 16", req_log.size()); end
        for (int i = 0; i < 16 && i < req_log.size(); i++) begin
            checks++;
            if (req_log[i] !== base + 32'(i * 4)) begin errors++; $display("FAIL toggle_req_addr%0d: got %h want %h", i, req_log[i], base + 32'(i * 4)); end
        end
        checks++; if (wdata_q.size() != 16) begin errors++; $display("FAIL toggle_beats: got %0d want 16", wdata_q.size()); end
        for (int i = 0; i < 16 && i < wdata_q.size(); i++) begin
            checks++;
            if (wdata_q[i] !== mdata(base + 32'(i * 4)) || wstrb_q[i] !== mstrb(base + 32'(i * 4)) || wlast_q[i] !== (i == 15)) begin
                errors++;
                $display("FAIL toggle_beat%0d: data=%h strb=%h last=%0b want %h/%h/%0b", i, wdata_q[i], wstrb_q[i], wlast_q[i], mdata(base + 32'(i * 4)), mstrb(base + 32'(i * 4)), (i == 15));
            end
        end
    endtask

    task automatic test_drop();
        logic [31:0] base;
        logic [31:0] exp_req [5];
        base = 32'h0000_0200;
        exp_req[0] = 32'h200; exp_req[1] = 32'h204; exp_req[2] = 32'h204;
        exp_req[3] = 32'h208; exp_req[4] = 32'h20C;
        drop_req = 1;
        start_burst(base, 8'd3);
        wait_idle("drop");
        drop_req = -1;
        checks++; if (req_log.size() != 5) begin errors++; $display("FAIL drop_req_count: got %0d want 5", req_log.size()); end
        for (int i = 0; i < 5 && i < req_log.size(); i++) begin
            checks++;
            if (req_log[i] !== exp_req[i]) begin errors++; $display("FAIL drop_req_addr%0d: got %h want %h", i, req_log[i], exp_req[i]); end
        end
        checks++; if (wdata_q.size() != 4) begin errors++; $display("FAIL drop_beats: got %0d want 4", wdata_q.size()); end
        for (int i = 0; i < 4 && i < wdata_q.size(); i++) begin
            checks++;
            if (wdata_q[i] !== mdata(base + 32'(i * 4)) || wlast_q[i] !== (i == 3)) begin
                errors++; $display("FAIL drop_beat%0d: data=%h last=%0b want %h/%0b", i, wdata_q[i], wlast_q[i], mdata(base + 32'(i * 4)), (i == 3));
            end
        end
    endtask

    task automatic test_bresp_error();
        bresp_cfg = 2'b10;
        start_burst(32'h0000_0400, 8'd1);
        wait_idle("bresp");
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL bresp_error_set: got %0b want 1", error); end
        checks++; if (wdata_q.size() != 2) begin errors++; $display("FAIL bresp_beats: got %0d want 2", wdata_q.size()); end
        bresp_cfg = 2'b00;
        start_burst(32'h0000_0500, 8'd0);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL bresp_error_clear: got %0b want 0", error); end
        wait_idle("bresp2");
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL bresp_error_ok: got %0b want 0", error); end
    endtask

    task automatic test_run_ignored();
        logic [31:0] base;
        base = 32'h0000_2000;
        wready_toggle = 1'b1;
        start_burst(base, 8'd7);
        repeat (4) @(posedge clk);
        #1;
        run  = 1'b1;
        addr = 32'h0000_9000;
        len  = 8'd2;
        @(posedge clk);
        #1;
        run = 1'b0;
        wait_idle("runign");
        wready_toggle = 1'b0;
        checks++; if (aw_cnt !== 1 || aw_addr_seen !== base || aw_len_seen !== 8'd7) begin errors++; $display("FAIL runign_aw: cnt=%0d addr=%h len=%0d want 1/%h/7", aw_cnt, aw_addr_seen, aw_len_seen, base); end
        checks++; if (wdata_q.size() != 8) begin errors++; $display("FAIL runign_beats: got %0d want 8", wdata_q.size()); end
        for (int i = 0; i < 8 && i < wdata_q.size(); i++) begin
            checks++;
            if (wdata_q[i] !== mdata(base + 32'(i * 4)) || wlast_q[i] !== (i == 7)) begin
                errors++; $display("FAIL runign_beat%0d: data=%h last=%0b want %h/%0b", i, wdata_q[i], wlast_q[i], mdata(base + 32'(i * 4)), (i == 7));
            end
        end
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b1 || bus.m_axi_awvalid_o !== 1'b0) begin errors++; $display("FAIL runign_stays_idle: ready=%0b awvalid=%0b want 1/0", ready, bus.m_axi_awvalid_o); end
    endtask

    task automatic test_reset_mid_burst();
        bit reached;
        logic [31:0] base;
        reached = 1'b0;
        start_burst(32'h0000_3000, 8'd7);
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk);
            if (wdata_q.size() >= 4) reached = 1'b1;
        end
        checks++; if (!reached) begin errors++; $display("FAIL midrst_reach: beats=%0d want 4", wdata_q.size()); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %0b want 1", ready); end
        checks++; if (bus.m_axi_wvalid_o !== 1'b0 || bus.m_valid_o !== 1'b0 || bus.m_axi_awvalid_o !== 1'b0 || bus.m_axi_bready_o !== 1'b0) begin
            errors++; $display("FAIL midrst_valids: w=%0b m=%0b aw=%0b b=%0b want 0/0/0/0", bus.m_axi_wvalid_o, bus.m_valid_o, bus.m_axi_awvalid_o, bus.m_axi_bready_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        base = 32'h0000_0300;
        start_burst(base, 8'd2);
        wait_idle("midrst");
        checks++; if (aw_cnt !== 1 || aw_addr_seen !== base || aw_len_seen !== 8'd2) begin errors++; $display("FAIL midrst_aw: cnt=%0d addr=%h len=%0d want 1/%h/2", aw_cnt, aw_addr_seen, aw_len_seen, base); end
        checks++; if (wdata_q.size() != 3) begin errors++; $display("FAIL midrst_beats: got %0d want 3", wdata_q.size()); end
        for (int i = 0; i < 3 && i < wdata_q.size(); i++) begin
            checks++;
            if (wdata_q[i] !== mdata(base + 32'(i * 4)) || wlast_q[i] !== (i == 2)) begin
                errors++; $display("FAIL midrst_beat%0d: data=%h last=%0b want %h/%0b", i, wdata_q[i], wlast_q[i], mdata(base + 32'(i * 4)), (i == 2));
            end
        end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL midrst_error: got %0b want 0", error); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wready_toggle();
        test_drop();
        test_bresp_error();
        test_run_ignored();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
